// File: rtl/stack_mem_ctrl.sv
// stack_mem_ctrl: sequences single-word stack push/pop accesses to a RAM with a
// ready handshake and a bounded wait.
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_wstackAddr         one-cycle request strobe from the stack pointer unit
//   i_stackAddr          word address of the request
//   i_push, i_pop        request kind (push wins when both are set)
//   i_pushData           data for a push
//   i_stackoverflow      pointer-unit error; a concurrent push is discarded
//   o_memAddr/o_memWData RAM address and write data, held for the whole access
//   o_memWe/o_memRe      RAM write/read enable, held until ready or timeout
//   i_memRData           RAM read data, valid with i_memReady during a read
//   i_memReady           RAM completion
//   o_readIt             pulse: pop data consumed, pointer may decrement
//   o_popData/o_popValid last popped word and its update pulse
//   o_busy               access in progress
//   o_timeout            pulse: access aborted after TIMEOUT waiting cycles
//   o_reqDropped         pulse: a request arrived while busy and was discarded
module stack_mem_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wstackAddr,
  input  logic [15:0] i_stackAddr,
  input  logic        i_push,
  input  logic        i_pop,
  input  logic [15:0] i_pushData,
  input  logic        i_stackoverflow,
  output logic [15:0] o_memAddr,
  output logic [15:0] o_memWData,
  output logic        o_memWe,
  output logic        o_memRe,
  input  logic [15:0] i_memRData,
  input  logic        i_memReady,
  output logic        o_readIt,
  output logic [15:0] o_popData,
  output logic        o_popValid,
  output logic        o_busy,
  output logic        o_timeout,
  output logic        o_reqDropped
);

  // The counter value seen in the last allowed waiting cycle.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StWr, StRd} state_e;

  state_e      r_state, w_state_next;
  logic [7:0]  r_cnt, w_cnt;
  logic [15:0] r_mem_addr, w_mem_addr;
  logic [15:0] r_mem_wdata, w_mem_wdata;
  logic [15:0] r_pop_data, w_pop_data;
  logic        r_mem_we, w_mem_we;
  logic        r_mem_re, w_mem_re;
  logic        r_read_it, w_read_it;
  logic        r_pop_valid, w_pop_valid;
  logic        r_busy, w_busy;
  logic        r_timeout, w_timeout;
  logic        r_req_dropped, w_req_dropped;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cnt         = r_cnt;
    w_mem_addr    = r_mem_addr;
    w_mem_wdata   = r_mem_wdata;
    w_pop_data    = r_pop_data;
    w_read_it     = 1'b0;
    w_pop_valid   = 1'b0;
    w_timeout     = 1'b0;
    w_req_dropped = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (i_wstackAddr) begin
          if (i_push) begin
            if (!i_stackoverflow) begin
              w_mem_addr   = i_stackAddr;
              w_mem_wdata  = i_pushData;
              w_cnt        = 8'd0;
              w_state_next = StWr;
            end
          end else if (i_pop) begin
            w_mem_addr   = i_stackAddr;
            w_cnt        = 8'd0;
            w_state_next = StRd;
          end
        end
      end
      StWr, StRd: begin
        w_req_dropped = i_wstackAddr;
        // Completion is checked first so a late ready still wins over timeout.
        if (i_memReady) begin
          w_state_next = StIdle;
          if (r_state == StRd) begin
            w_pop_data  = i_memRData;
            w_pop_valid = 1'b1;
            w_read_it   = 1'b1;
          end
        end else if (r_cnt == TimeoutLast) begin
          w_timeout    = 1'b1;
          w_state_next = StIdle;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      default: w_state_next = StIdle;
    endcase

    // Enables and busy are registered copies of the next state.
    w_mem_we = (w_state_next == StWr);
    w_mem_re = (w_state_next == StRd);
    w_busy   = (w_state_next != StIdle);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt         <= 8'd0;
      r_mem_addr    <= 16'd0;
      r_mem_wdata   <= 16'd0;
      r_pop_data    <= 16'd0;
      r_mem_we      <= 1'b0;
      r_mem_re      <= 1'b0;
      r_read_it     <= 1'b0;
      r_pop_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout     <= 1'b0;
      r_req_dropped <= 1'b0;
    end else begin
      r_cnt         <= w_cnt;
      r_mem_addr    <= w_mem_addr;
      r_mem_wdata   <= w_mem_wdata;
      r_pop_data    <= w_pop_data;
      r_mem_we      <= w_mem_we;
      r_mem_re      <= w_mem_re;
      r_read_it     <= w_read_it;
      r_pop_valid   <= w_pop_valid;
      r_busy        <= w_busy;
      r_timeout     <= w_timeout;
      r_req_dropped <= w_req_dropped;
    end
  end

  assign o_memAddr    = r_mem_addr;
  assign o_memWData   = r_mem_wdata;
  assign o_memWe      = r_mem_we;
  assign o_memRe      = r_mem_re;
  assign o_readIt     = r_read_it;
  assign o_popData    = r_pop_data;
  assign o_popValid   = r_pop_valid;
  assign o_busy       = r_busy;
  assign o_timeout    = r_timeout;
  assign o_reqDropped = r_req_dropped;

endmodule

// File: tb/tb_stack_mem_ctrl.sv
// tb_stack_mem_ctrl: table-driven bench for stack_mem_ctrl with TIMEOUT=4.
// Each table row is one clock cycle: inputs applied before the edge, outputs
// checked just after it.
module tb_stack_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, wsa, push, pop, ovf, rdy;
  logic [15:0] saddr, pdata, rdata;
  logic [15:0] maddr, mwdata, popd;
  logic        we, re, rd_it, pv, busy, tmo, drop;

  always #5 clk = ~clk;

  stack_mem_ctrl #(.TIMEOUT(4)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_wstackAddr   (wsa),
    .i_stackAddr    (saddr),
    .i_push         (push),
    .i_pop          (pop),
    .i_pushData     (pdata),
    .i_stackoverflow(ovf),
    .o_memAddr      (maddr),
    .o_memWData     (mwdata),
    .o_memWe        (we),
    .o_memRe        (re),
    .i_memRData     (rdata),
    .i_memReady     (rdy),
    .o_readIt       (rd_it),
    .o_popData      (popd),
    .o_popValid     (pv),
    .o_busy         (busy),
    .o_timeout      (tmo),
    .o_reqDropped   (drop)
  );

  // ctl  = {rst, wstackAddr, push, pop, stackoverflow, memReady}
  // eflg = {busy, memWe, memRe, readIt, popValid, timeout, reqDropped}
  typedef struct {
    logic [5:0]  ctl;
    logic [15:0] addr;
    logic [15:0] pdata;
    logic [15:0] rdata;
    logic [6:0]  eflg;
    logic [15:0] eaddr;
    logic [15:0] ewdata;
    logic [15:0] epdata;
  } vec_t;

  localparam int NumVec = 35;
  vec_t tbl [NumVec];

  int errors = 0;
  int checks = 0;

  function automatic logic [15:0] flags();
    return {9'd0, busy, we, re, rd_it, pv, tmo, drop};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [5:0] ctl, input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] r);
    @(negedge clk);
    {rst, wsa, push, pop, ovf, rdy} = ctl;
    saddr = a;
    pdata = d;
    rdata = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    {rst, wsa, push, pop, ovf, rdy} = 6'b100000;
    saddr = 16'h0; pdata = 16'h0; rdata = 16'h0;

    tbl[0]  = '{6'b100000, 16'h0000, 16'h0000, 16'h0000, 7'b0000000, 16'h0000, 16'h0000, 16'h0000};
    tbl[1]  = '{6'b000000, 16'h0000, 16'h0000, 16'h0000, 7'b0000000, 16'h0000, 16'h0000, 16'h0000};
    // push 0x4601/0xBEEF, ready two cycles after the request
    tbl[2]  = '{6'b011000, 16'h4601, 16'hBEEF, 16'h0000, 7'b1100000, 16'h4601, 16'hBEEF, 16'h0000};
    tbl[3]  = '{6'b000000, 16'h0000, 16'h0000, 16'h0000, 7'b1100000, 16'h4601, 16'hBEEF, 16'h0000};
    tbl[4]  = '{6'b000001, 16'h0000, 16'h0000, 16'h0000, 7'b0000000, 16'h4601, 16'hBEEF, 16'h0000};
    // minimum-latency pop
    tbl[5]  = '{6'b010100, 16'h4601, 16'h0000, 16'h0000, 7'b1010000, 16'h4601, 16'hBEEF, 16'h0000};
    tbl[6]  = '{6'b000001, 16'h0000, 16'h0000, 16'hBEEF, 7'b0001100, 16'h4601, 16'hBEEF, 16'hBEEF};
    tbl[7]  = '{6'b000000, 16'h0000, 16'h0000, 16'h0000, 7'b0000000, 16'h4601, 16'hBEEF, 16'hBEEF};
    // overflowed push, strobe with no kind, idle ready: all ignored
    tbl[8]  = '{6'b011010, 16'h1234, 16'h5555, 16'h0000, 7'b0000000, 16'h4601, 16'hBEEF, 16'hBEEF};
    tbl[9]  = '{6'b000000, 16'h0000, 16'h0000, 16'h0000, 7'b0000000, 16'h4601, 16'hBEEF, 16'hBEEF};
    tbl[10] = '{6'b010000, 16'h2222, 16'h0000, 16'h0000, 7'b0000000, 16'h4601, 16'hBEEF, 16'hBEEF};
    tbl[11] = '{6'b000001, 16'h0000, 16'h0000, 16'h1111, 7'b0000000, 16'h4601, 16'hBEEF, 16'hBEEF};
    // request during a read is dropped; read keeps its address
    tbl[12] = '{6'b010100, 16'h0010, 16'h0000, 16'h0000, 7'b1010000, 16'h0010, 16'hBEEF, 16'hBEEF};
    tbl[13] = '{6'b011000, 16'h2222, 16'h3333, 16'h0000, 7'b1010001, 16'h0010, 16'hBEEF, 16'hBEEF};
    tbl[14] = '{6'b000001, 16'h0000, 16'h0000, 16'hCAFE, 7'b0001100, 16'h0010, 16'hBEEF, 16'hCAFE};
    // back-to-back request right after completion
    tbl[15] = '{6'b011000, 16'h0011, 16'hA5A5, 16'h0000, 7'b1100000, 16'h0011, 16'hA5A5, 16'hCAFE};
    tbl[16] = '{6'b000001, 16'h0000, 16'h0000, 16'h0000, 7'b0000000, 16'h0011, 16'hA5A5, 16'hCAFE};
    // push and pop together: push wins; strobe in the completing cycle is dropped
    tbl[17] = '{6'b011100, 16'h0020, 16'h7777, 16'h0000, 7'b1100000, 16'h0020, 16'h7777, 16'hCAFE};
    tbl[18] = '{6'b010101, 16'h0099, 16'h0000, 16'h0000, 7'b0000001, 16'h0020, 16'h7777, 16'hCAFE};
    // pop with no ready: four read cycles then timeout, popData unchanged
    tbl[19] = '{6'b010100, 16'h0030, 16'h0000, 16'h0000, 7'b1010000, 16'h0030, 16'h7777, 16'hCAFE};
    tbl[20] = '{6'b000000, 16'h0000, 16'h0000, 16'h0000, 7'b1010000, 16'h0030, 16'h7777, 16'hCAFE};
    tbl[21] = '{6'b000000, 16'h0000, 16'h0000, 16'h0000, 7'b1010000, 16'h0030, 16'h7777, 16'hCAFE};
    tbl[22] = '{6'b000000, 16'h0000, 16'h0000, 16'h0000, 7'b1010000, 16'h0030, 16'h7777, 16'hCAFE};
    tbl[23] = '{6'b000000, 16'h0000, 16'h0000, 16'hDEAD, 7'b0000010, 16'h0030, 16'h7777, 16'hCAFE};
    tbl[24] = '{6'b000000, 16'h0000, 16'h0000, 16'h0000, 7'b0000000, 16'h0030, 16'h7777, 16'hCAFE};
    // ready in the last allowed cycle: completion wins
    tbl[25] = '{6'b010100, 16'h0040, 16'h0000, 16'h0000, 7'b1010000, 16'h0040, 16'h7777, 16'hCAFE};
    tbl[26] = '{6'b000000, 16'h0000, 16'h0000, 16'h0000, 7'b1010000, 16'h0040, 16'h7777, 16'hCAFE};
    tbl[27] = '{6'b000000, 16'h0000, 16'h0000, 16'h0000, 7'b1010000, 16'h0040, 16'h7777, 16'hCAFE};
    tbl[28] = '{6'b000000, 16'h0000, 16'h0000, 16'h0000, 7'b1010000, 16'h0040, 16'h7777, 16'hCAFE};
    tbl[29] = '{6'b000001, 16'h0000, 16'h0000, 16'h1357, 7'b0001100, 16'h0040, 16'h7777, 16'h1357};
    // reset during a write, with a competing request; later ready ignored
    tbl[30] = '{6'b011000, 16'h0050, 16'h9999, 16'h0000, 7'b1100000, 16'h0050, 16'h9999, 16'h1357};
    tbl[31] = '{6'b111000, 16'h0060, 16'h4444, 16'h0000, 7'b0000000, 16'h0000, 16'h0000, 16'h0000};
    tbl[32] = '{6'b000001, 16'h0000, 16'h0000, 16'hFFFF, 7'b0000000, 16'h0000, 16'h0000, 16'h0000};
    tbl[33] = '{6'b011000, 16'h0070, 16'h0F0F, 16'h0000, 7'b1100000, 16'h0070, 16'h0F0F, 16'h0000};
    tbl[34] = '{6'b000001, 16'h0000, 16'h0000, 16'h0000, 7'b0000000, 16'h0070, 16'h0F0F, 16'h0000};

    for (int i = 0; i < NumVec; i++) begin
      apply(tbl[i].ctl, tbl[i].addr, tbl[i].pdata, tbl[i].rdata);
      check($sformatf("vec%0d flags", i), flags(), {9'd0, tbl[i].eflg});
      check($sformatf("vec%0d memAddr", i), maddr, tbl[i].eaddr);
      check($sformatf("vec%0d memWData", i), mwdata, tbl[i].ewdata);
      check($sformatf("vec%0d popData", i), popd, tbl[i].epdata);
    end

    // Reset in the same cycle as a read completes: no pop is reported.
    apply(6'b010100, 16'h0080, 16'h0000, 16'h0000);
    check("rstrd start flags", flags(), 16'h0050);
    apply(6'b100001, 16'h0000, 16'h0000, 16'hABCD);
    check("rstrd abort flags", flags(), 16'h0000);
    check("rstrd abort popData", popd, 16'h0000);
    apply(6'b000000, 16'h0000, 16'h0000, 16'h0000);
    check("rstrd idle flags", flags(), 16'h0000);

    // A normal pop afterwards still works.
    apply(6'b010100, 16'h0090, 16'h0000, 16'h0000);
    check("pop2 memAddr", maddr, 16'h0090);
    apply(6'b000001, 16'h0000, 16'h0000, 16'h2468);
    check("pop2 flags", flags(), 16'h000C);
    check("pop2 popData", popd, 16'h2468);
    apply(6'b000000, 16'h0000, 16'h0000, 16'h0000);
    check("pop2 idle flags", flags(), 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stack_mem_ctrl.md
STACK_MEM_CTRL -- requirements
Module: stack_mem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, max cycles a memory access waits for memReady before abort; range 1..255.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 wstackAddr  input  1  one-cycle stack access request strobe from the stack pointer unit.
REQ-005 stackAddr  input  16  word address for the access, valid with wstackAddr.
REQ-006 push  input  1  request is a push, sampled with wstackAddr.
REQ-007 pop  input  1  request is a pop, sampled with wstackAddr.
REQ-008 pushData  input  16  data to store, sampled with wstackAddr&push.
REQ-009 stackoverflow  input  1  pointer-unit error flag; a push request in the same cycle is discarded.
REQ-010 memAddr  output  16  RAM word address.
REQ-011 memWData  output  16  RAM write data.
REQ-012 memWe  output  1  RAM write enable, held until memReady or timeout.
REQ-013 memRe  output  1  RAM read enable, held until memReady or timeout.
REQ-014 memRData  input  16  RAM read data, valid when memReady&memRe.
REQ-015 memReady  input  1  RAM completion for the current access.
REQ-016 readIt  output  1  one-cycle pulse to the pointer unit: pop data consumed, decrement pointer.
REQ-017 popData  output  16  last popped word, holds until next successful pop.
REQ-018 popValid  output  1  one-cycle pulse, popData updated.
REQ-019 busy  output  1  high in any state other than IDLE.
REQ-020 timeout  output  1  one-cycle pulse, access aborted after TIMEOUT cycles.
REQ-021 reqDropped  output  1  one-cycle pulse, wstackAddr arrived while busy.

Function
REQ-022 FSM states IDLE, WR, RD; all outputs registered.
REQ-023 IDLE: wstackAddr&push&!stackoverflow -> latch stackAddr, pushData; go WR.
REQ-024 IDLE: wstackAddr&push&stackoverflow -> no access, stay IDLE.
REQ-025 IDLE: wstackAddr&!push&pop -> latch stackAddr; go RD; push has priority when both set.
REQ-026 IDLE: wstackAddr with neither push nor pop -> ignored.
REQ-027 Request in cycle N -> memWe/memRe, memAddr, memWData, busy valid from cycle N+1.
REQ-028 WR: memWe=1; memReady -> go IDLE next edge, memWe=0 at that edge.
REQ-029 RD: memRe=1; memReady -> popData<=memRData, popValid=1 and readIt=1 for exactly one cycle, go IDLE.
REQ-030 Minimum pop latency: request cycle N, memReady at N+1 -> readIt/popValid high at N+2, busy low at N+2.
REQ-031 Wait counter, 8 bits, cleared on WR/RD entry, incremented each WR/RD cycle without memReady.
REQ-032 Counter reaches TIMEOUT -> timeout pulse, return IDLE, no readIt, no popValid, popData unchanged.
REQ-033 memReady in same cycle the counter reaches TIMEOUT -> completion wins, no timeout.
REQ-034 wstackAddr while busy -> request discarded, reqDropped pulses next cycle; active access unaffected.
REQ-035 memReady while IDLE -> ignored.
REQ-036 memAddr/memWData hold latched values throughout WR/RD; memWData don't-care in RD.
REQ-037 Request in the cycle state returns to IDLE is accepted normally (back-to-back, one idle cycle min).

Reset
REQ-038 rst high at a clock edge -> state IDLE, counter 0, popData 0, memAddr 0, memWData 0, all 1-bit outputs 0.
REQ-039 rst mid-access aborts it: no readIt, popValid, or timeout pulse generated.
REQ-040 rst has priority over every other input.

Verification
REQ-041 push addr 0x4601 data 0xBEEF, memReady 2 cycles later -> memWe high 2 cycles at 0x4601/0xBEEF, then busy 0.
REQ-042 pop addr 0x4601, memReady at N+1 with memRData 0xBEEF -> popData 0xBEEF, popValid and readIt pulse at N+2.
REQ-043 pop, memReady never, TIMEOUT=4 -> memRe high 4 cycles, timeout pulse, no readIt, popData unchanged.
REQ-044 push with stackoverflow=1 -> memWe never asserts, busy stays 0.
REQ-045 second wstackAddr during RD -> reqDropped pulse; first pop completes with its original address.
REQ-046 rst asserted during WR -> next edge memWe=0, busy=0; later memReady ignored.
